updown_counter_mod: RTL and testbench
=====================================

Name: updown_counter_mod

Overview:
Parametrised up/down counter with load. It generalises the team's fixed 4-bit load counter in three ways:
- configurable width and modulus (0..MAX);
- a selectable wrap or saturate mode at the boundaries;
- terminal-count and overflow outputs for cascading, such as BCD digits and timer prescalers.

Control priority is fixed and documented; simultaneous load and count are fully defined.

Parameters:
WIDTH, 8, counter width in bits (>=2)
MAX, 2**WIDTH-1, highest count value; count range is 0..MAX; MAX <= 2**WIDTH-1
SATURATE, 0, 0 = wrap at boundaries, 1 = hold at boundaries

Ports:
clk  input  1  rising-edge clock
t_n  input  1  asynchronous active-low reset
clr  input  1  synchronous clear
c  input  1  count enable
u  input  1  direction: 1 = up, 0 = down
l  input  1  synchronous load
i  input  WIDTH  load value
r  output  WIDTH  current count (registered)
tc  output  1  terminal count (combinational)
ovf  output  1  boundary-event pulse (registered)

Behaviour:
- Clock and reset (already decided):
  - One clock, clk; all state updates on its rising edge.
  - t_n is asynchronous, active-low.
  - t_n = 0 forces r = 0 and ovf = 0 immediately, independent of clk, and holds them while low.
  - Deassertion of t_n is synchronised externally.
- Per-edge priority (highest first); exactly one action per edge:
  1. clr = 1: r <= 0; ovf <= 0.
  2. l = 1: r <= (i > MAX) ? MAX : i; ovf <= 0.
     - Load overrides count; c is ignored in that cycle.
  3. c = 1, u = 1:
     - r < MAX: r <= r + 1.
     - r == MAX, SATURATE = 0: r <= 0.
     - r == MAX, SATURATE = 1: r <= MAX.
  4. c = 1, u = 0:
     - r > 0: r <= r - 1.
     - r == 0, SATURATE = 0: r <= MAX.
     - r == 0, SATURATE = 1: r <= 0.
  5. Otherwise: r holds.
- ovf:
  - Registered; goes high for exactly one cycle, on the edge at which a count action (items 3/4) occurs at the boundary (up at MAX, or down at 0), in either mode.
  - All other edges: ovf <= 0.
  - Back-to-back boundary events (saturate mode, c held) keep ovf high every cycle.
- tc:
  - Combinational: tc = c & ~clr & ~l & ((u & r == MAX) | (~u & r == 0)).
  - It announces that the next edge is a boundary event.
  - Intended to drive the c input of the next cascaded stage in the same cycle.
- Arithmetic:
  - Internal compare and increment use WIDTH bits.
  - r never leaves 0..MAX, including when MAX < 2**WIDTH-1 (no intermediate value above MAX is ever observable).
- Direction change:
  - u may change on any cycle; it takes effect at the next edge. No extra latency.
- Reset mid-operation:
  - t_n low overrides every input at any time.
  - The first edge after release acts on the inputs present then.
- Latency: 1 clock from input to r and ovf; 0 clocks from inputs to tc.

Test Plan:
1. Reset: WIDTH=4, MAX=9. Assert t_n=0 mid-count at r=5 between edges -> r=0 and ovf=0 immediately, before the next edge; release; c=1, u=1 -> r=1 after one edge.
2. Decade wrap: WIDTH=4, MAX=9, SATURATE=0; count up from 0 for 12 edges -> r sequence 1..9,0,1,2. tc=1 only while r=9. ovf=1 for exactly the cycle after r goes 9->0.
3. Down wrap and saturate:
   - SATURATE=0, from r=0 with u=0, c=1 -> r=9, ovf pulse.
   - SATURATE=1, from r=0 for 3 edges -> r stays 0, ovf=1 on all 3 cycles; then u=1 -> r=1, ovf=0.
4. Priority:
   - At r=3, assert l=1, c=1, i=7 -> r=7, not 8.
   - Assert clr=1, l=1, c=1 together -> r=0.
   - Load i=15 with MAX=9 -> r=9.
5. Cascade: two instances, MAX=9, stage-1 c driven by stage-0 tc; count 100 edges from 00 -> digits read 0,0 again. Stage-1 steps only on edges where stage 0 goes 9->0.
6. Direction flip at the boundary: r=9, u=1, c=1 with u toggled to 0 before the edge -> r=8, no ovf. tc=0 during that cycle after the toggle.

Source files
------------

// File: rtl/updown_counter_mod.sv
// updown_counter_mod: parametrised up/down counter with synchronous clear and
// load, wrap or saturate at 0/MAX, combinational terminal count for cascading
// and a registered one-cycle boundary pulse.
module updown_counter_mod #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX      = 2**WIDTH-1,
  parameter bit          SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             t_n,
  input  logic             clr,
  input  logic             c,
  input  logic             u,
  input  logic             l,
  input  logic [WIDTH-1:0] i,
  output logic [WIDTH-1:0] r,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_V      = MAX[WIDTH-1:0];
  localparam bit               FULL_RANGE = (MAX == 2**WIDTH-1);

  logic [WIDTH-1:0] r_count;
  logic             r_ovf;

  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_next;
  logic             w_ovf_next;
  logic             w_at_max;
  logic             w_at_zero;

  assign w_at_max  = (r_count == MAX_V);
  assign w_at_zero = (r_count == '0);

  // Load value clamped to MAX; with a full-range modulus no clamp is needed
  // and the comparison would be constant, so it is left out entirely.
  generate
    if (FULL_RANGE) begin : g_load_full
      always_comb w_load_val = i;
    end else begin : g_load_clamp
      always_comb w_load_val = (i > MAX_V) ? MAX_V : i;
    end
  endgenerate

  // Next count and boundary flag: clear, then load, then count; hold otherwise.
  always_comb begin
    w_next     = r_count;
    w_ovf_next = 1'b0;
    if (clr) begin
      w_next = '0;
    end else if (l) begin
      w_next = w_load_val;
    end else if (c) begin
      if (u) begin
        if (w_at_max) begin
          w_ovf_next = 1'b1;
          w_next     = SATURATE ? MAX_V : '0;
        end else begin
          w_next = r_count + 1'b1;
        end
      end else begin
        if (w_at_zero) begin
          w_ovf_next = 1'b1;
          w_next     = SATURATE ? '0 : MAX_V;
        end else begin
          w_next = r_count - 1'b1;
        end
      end
    end
  end

  // Count and boundary-pulse registers, cleared asynchronously by t_n.
  always_ff @(posedge clk or negedge t_n) begin
    if (!t_n) begin
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_next;
      r_ovf   <= w_ovf_next;
    end
  end

  // Terminal count: the coming edge is a boundary count event.
  always_comb begin
    tc = c & ~clr & ~l & ((u & w_at_max) | (~u & w_at_zero));
  end

  assign r   = r_count;
  assign ovf = r_ovf;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: wrap (A) and saturate (B) decade counters plus
// a two-digit cascade; expected r/ovf queued at issue, checked by a monitor.
module tb_updown_counter_mod;

  logic clk = 1'b0;
  logic t_n = 1'b0;

  logic       a_clr = 0, a_c = 0, a_u = 0, a_l = 0;
  logic [3:0] a_i = '0, a_r;
  logic       a_tc, a_ovf;
  logic       b_clr = 0, b_c = 0, b_u = 0, b_l = 0;
  logic [3:0] b_i = '0, b_r;
  logic       b_tc, b_ovf;
  logic       cas_en = 0;
  logic [3:0] c0_r, c1_r;
  logic       c0_tc, c1_tc, c0_ovf, c1_ovf;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    int         kind;  // 0 = A, 1 = B, 2 = cascade {tens,ones}
    string      name;
    logic [7:0] r;
    logic [1:0] ovf;
  } sb_t;
  sb_t sb[$];

  always #5 clk = ~clk;

  updown_counter_mod #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_a (
    .clk(clk), .t_n(t_n), .clr(a_clr), .c(a_c), .u(a_u), .l(a_l), .i(a_i),
    .r(a_r), .tc(a_tc), .ovf(a_ovf));
  updown_counter_mod #(.WIDTH(4), .MAX(9), .SATURATE(1'b1)) u_b (
    .clk(clk), .t_n(t_n), .clr(b_clr), .c(b_c), .u(b_u), .l(b_l), .i(b_i),
    .r(b_r), .tc(b_tc), .ovf(b_ovf));
  updown_counter_mod #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_c0 (
    .clk(clk), .t_n(t_n), .clr(1'b0), .c(cas_en), .u(1'b1), .l(1'b0), .i(4'd0),
    .r(c0_r), .tc(c0_tc), .ovf(c0_ovf));
  updown_counter_mod #(.WIDTH(4), .MAX(9), .SATURATE(1'b0)) u_c1 (
    .clk(clk), .t_n(t_n), .clr(1'b0), .c(c0_tc), .u(1'b1), .l(1'b0), .i(4'd0),
    .r(c1_r), .tc(c1_tc), .ovf(c1_ovf));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: every falling edge after an issued vector presents the result.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      sb_t e;
      logic [7:0] ar;
      logic [1:0] ao;
      e = sb.pop_front();
      case (e.kind)
        0:       begin ar = {4'd0, a_r};  ao = {1'b0, a_ovf};   end
        1:       begin ar = {4'd0, b_r};  ao = {1'b0, b_ovf};   end
        default: begin ar = {c1_r, c0_r}; ao = {c1_ovf, c0_ovf}; end
      endcase
      chk({e.name, "_r"}, 32'(ar), 32'(e.r));
      chk({e.name, "_ovf"}, 32'(ao), 32'(e.ovf));
    end
  end

  task automatic push(input int kind, input string nm, input logic [7:0] er, input logic [1:0] eo);
    sb_t e;
    e.kind = kind; e.name = nm; e.r = er; e.ovf = eo;
    sb.push_back(e);
  endtask

  // Drive one vector on dut sel (other dut idle), check tc, queue r/ovf.
  task automatic apply(input int sel, input string nm, input logic clr_v, input logic l_v,
                       input logic c_v, input logic u_v, input logic [3:0] i_v,
                       input logic exp_tc, input logic [3:0] exp_r, input logic exp_ovf);
    @(negedge clk);
    #1;
    a_clr = 0; a_l = 0; a_c = 0; a_u = 0; a_i = '0;
    b_clr = 0; b_l = 0; b_c = 0; b_u = 0; b_i = '0;
    if (sel == 0) begin a_clr = clr_v; a_l = l_v; a_c = c_v; a_u = u_v; a_i = i_v; end
    else          begin b_clr = clr_v; b_l = l_v; b_c = c_v; b_u = u_v; b_i = i_v; end
    #1;
    chk({nm, "_tc"}, 32'(sel == 0 ? a_tc : b_tc), 32'(exp_tc));
    push(sel, nm, {4'd0, exp_r}, {1'b0, exp_ovf});
  endtask

  task automatic idle_all;
    a_clr = 0; a_l = 0; a_c = 0; a_u = 0; a_i = '0;
    b_clr = 0; b_l = 0; b_c = 0; b_u = 0; b_i = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [3:0] exp_up [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd0, 4'd1, 4'd2};

  initial begin
    // 1. Reset state and asynchronous reset mid-count
    #2;
    chk("rst_a_r", 32'(a_r), 0);   chk("rst_a_ovf", 32'(a_ovf), 0);
    chk("rst_b_r", 32'(b_r), 0);   chk("rst_c_r", 32'({c1_r, c0_r}), 0);
    @(negedge clk); #1; t_n = 1'b1;
    for (int k = 1; k <= 5; k++) apply(0, "pre_rst", 0, 0, 1, 1, 4'd0, 0, 4'(k), 0);
    @(negedge clk); #1;
    t_n = 1'b0;
    #1;
    chk("async_rst_a_r", 32'(a_r), 0);
    chk("async_rst_a_ovf", 32'(a_ovf), 0);
    #1; t_n = 1'b1;
    push(0, "post_rst", 8'd1, 2'd0);

    // 2. Decade wrap upwards
    apply(0, "clr2", 1, 0, 0, 0, 4'd0, 0, 4'd0, 0);
    for (int k = 0; k < 12; k++)
      apply(0, "wrap_up", 0, 0, 1, 1, 4'd0, (k == 9), exp_up[k], (k == 9));
    apply(0, "wrap_hold", 0, 0, 0, 1, 4'd0, 0, 4'd2, 0);

    // 3a. Down wrap from 0
    apply(0, "clr3", 1, 0, 0, 0, 4'd0, 0, 4'd0, 0);
    apply(0, "down_wrap", 0, 0, 1, 0, 4'd0, 1, 4'd9, 1);
    apply(0, "down_idle", 0, 0, 0, 0, 4'd0, 0, 4'd9, 0);

    // 3b. Saturate at 0, async reset while ovf high, then up
    apply(1, "sat_clr", 1, 0, 0, 0, 4'd0, 0, 4'd0, 0);
    for (int k = 0; k < 3; k++) apply(1, "sat_down", 0, 0, 1, 0, 4'd0, 1, 4'd0, 1);
    @(negedge clk); #1;
    idle_all();
    t_n = 1'b0;
    #1;
    chk("rst_sat_ovf", 32'(b_ovf), 0);
    chk("rst_sat_r", 32'(b_r), 0);
    #1; t_n = 1'b1;
    apply(1, "sat_up", 0, 0, 1, 1, 4'd0, 0, 4'd1, 0);
    apply(1, "sat_ld9", 0, 1, 0, 0, 4'd9, 0, 4'd9, 0);
    apply(1, "sat_top", 0, 0, 1, 1, 4'd0, 1, 4'd9, 1);
    apply(1, "sat_top2", 0, 0, 1, 1, 4'd0, 1, 4'd9, 1);
    apply(1, "sat_idle", 0, 0, 0, 1, 4'd0, 0, 4'd9, 0);

    // 4. Priority and load clamp
    apply(0, "clr4", 1, 0, 0, 0, 4'd0, 0, 4'd0, 0);
    apply(0, "ld3", 0, 1, 0, 0, 4'd3, 0, 4'd3, 0);
    apply(0, "ld_over_cnt", 0, 1, 1, 1, 4'd7, 0, 4'd7, 0);
    apply(0, "clr_over_all", 1, 1, 1, 1, 4'd5, 0, 4'd0, 0);
    apply(0, "ld10_clamp", 0, 1, 0, 0, 4'd10, 0, 4'd9, 0);
    apply(0, "clr5", 1, 0, 0, 0, 4'd0, 0, 4'd0, 0);
    apply(0, "ld15_clamp", 0, 1, 0, 0, 4'd15, 0, 4'd9, 0);
    apply(0, "ld_at_max", 0, 1, 1, 1, 4'd9, 0, 4'd9, 0);
    apply(0, "clr_at_max", 1, 0, 1, 1, 4'd0, 0, 4'd0, 0);

    // 6. Direction flip at the boundary before the edge
    apply(0, "ld9b", 0, 1, 0, 0, 4'd9, 0, 4'd9, 0);
    @(negedge clk); #1;
    a_clr = 0; a_l = 0; a_c = 1; a_u = 1;
    #1; chk("flip_tc_before", 32'(a_tc), 1);
    a_u = 0;
    #1; chk("flip_tc_after", 32'(a_tc), 0);
    push(0, "flip", 8'd8, 2'd0);

    // 5. Two-digit cascade over 100 edges
    @(negedge clk); #1; idle_all();
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk); #1;
      cas_en = 1'b1;
      #1;
      chk("cas_tc0", 32'(c0_tc), 32'(((k - 1) % 10) == 9));
      push(2, "cas", {4'((k / 10) % 10), 4'(k % 10)}, {(k % 100) == 0, (k % 10) == 0});
    end
    @(negedge clk); #1; cas_en = 1'b0;
    @(negedge clk); #1;
    chk("sb_drain", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
